// File: rtl/peripheral_biu_initiator.sv
// Single-outstanding bus initiator: turns one command into one BIU strobe/ack
// transaction and returns a response (data, bus error, timeout).
module peripheral_biu_initiator #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned PLEN    = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            cmd_valid_i,
   output logic            cmd_ready_o,
   input  logic            cmd_we_i,
   input  logic [PLEN-1:0] cmd_adr_i,
   input  logic [XLEN-1:0] cmd_d_i,
   input  logic [2:0]      cmd_size_i,
   input  logic [2:0]      cmd_prot_i,

   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [XLEN-1:0] rsp_q_o,
   output logic            rsp_err_o,
   output logic            rsp_tmo_o,

   output logic            biu_stb_o,
   output logic            biu_we_o,
   output logic            biu_lock_o,
   output logic [PLEN-1:0] biu_adri_o,
   output logic [XLEN-1:0] biu_d_o,
   output logic [2:0]      biu_size_o,
   output logic [2:0]      biu_type_o,
   output logic [2:0]      biu_prot_o,
   input  logic            biu_stb_ack_i,
   input  logic            biu_d_ack_i,
   input  logic            biu_ack_i,
   input  logic            biu_err_i,
   input  logic [XLEN-1:0] biu_q_i,
   input  logic [PLEN-1:0] biu_adro_i
);

   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t        state;
   logic [CW-1:0] tmo_cnt;
   logic          bus_done;
   logic          tmo_hit;
   logic          unused_inputs;

   assign cmd_ready_o   = (state == IDLE);
   assign biu_lock_o    = 1'b0;
   assign biu_type_o    = 3'b000;
   assign unused_inputs = ^{biu_adro_i, biu_d_ack_i};

   // A completion may arrive with the strobe acknowledge itself; it beats a
   // timeout that expires in the same cycle.
   assign bus_done = (biu_ack_i | biu_err_i) &
                     ((state == WAIT) | ((state == REQ) & biu_stb_ack_i));
   assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         tmo_cnt     <= '0;
         biu_stb_o   <= 1'b0;
         biu_we_o    <= 1'b0;
         biu_adri_o  <= '0;
         biu_d_o     <= '0;
         biu_size_o  <= '0;
         biu_prot_o  <= '0;
         rsp_valid_o <= 1'b0;
         rsp_q_o     <= '0;
         rsp_err_o   <= 1'b0;
         rsp_tmo_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  biu_we_o   <= cmd_we_i;
                  biu_adri_o <= cmd_adr_i;
                  biu_d_o    <= cmd_d_i;
                  biu_size_o <= cmd_size_i;
                  biu_prot_o <= cmd_prot_i;
                  biu_stb_o  <= 1'b1;
                  tmo_cnt    <= '0;
                  rsp_q_o    <= '0;
                  rsp_err_o  <= 1'b0;
                  rsp_tmo_o  <= 1'b0;
                  state      <= REQ;
               end
            end
            REQ, WAIT: begin
               tmo_cnt <= tmo_cnt + CW'(1);
               if (bus_done) begin
                  biu_stb_o   <= 1'b0;
                  rsp_q_o     <= biu_we_o ? '0 : biu_q_i;
                  rsp_err_o   <= biu_err_i;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if (tmo_hit) begin
                  biu_stb_o   <= 1'b0;
                  rsp_err_o   <= 1'b1;
                  rsp_tmo_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  state       <= RESP;
               end else if ((state == REQ) && biu_stb_ack_i) begin
                  biu_stb_o <= 1'b0;
                  state     <= WAIT;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_peripheral_biu_initiator.sv
// Directed self-checking bench for peripheral_biu_initiator (TIMEOUT set to 8).
module tb_peripheral_biu_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
   logic        cmd_ready_o;
   logic [63:0] cmd_adr_i = '0, cmd_d_i = '0;
   logic [2:0]  cmd_size_i = '0, cmd_prot_i = '0;
   logic        rsp_valid_o, rsp_err_o, rsp_tmo_o;
   logic        rsp_ready_i = 1'b0;
   logic [63:0] rsp_q_o;
   logic        biu_stb_o, biu_we_o, biu_lock_o;
   logic [63:0] biu_adri_o, biu_d_o;
   logic [2:0]  biu_size_o, biu_type_o, biu_prot_o;
   logic        biu_stb_ack_i = 1'b0, biu_d_ack_i = 1'b0, biu_ack_i = 1'b0, biu_err_i = 1'b0;
   logic [63:0] biu_q_i = '0, biu_adro_i = '0;

   int checks = 0;
   int errors = 0;

   peripheral_biu_initiator #(.XLEN(64), .PLEN(64), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
      .cmd_adr_i(cmd_adr_i), .cmd_d_i(cmd_d_i), .cmd_size_i(cmd_size_i), .cmd_prot_i(cmd_prot_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_q_o(rsp_q_o),
      .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
      .biu_stb_o(biu_stb_o), .biu_we_o(biu_we_o), .biu_lock_o(biu_lock_o),
      .biu_adri_o(biu_adri_o), .biu_d_o(biu_d_o), .biu_size_o(biu_size_o),
      .biu_type_o(biu_type_o), .biu_prot_o(biu_prot_o),
      .biu_stb_ack_i(biu_stb_ack_i), .biu_d_ack_i(biu_d_ack_i), .biu_ack_i(biu_ack_i),
      .biu_err_i(biu_err_i), .biu_q_i(biu_q_i), .biu_adro_i(biu_adro_i)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic we, input logic [63:0] adr, input logic [63:0] d,
                           input logic [2:0] size, input logic [2:0] prot);
      cmd_valid_i = 1'b1; cmd_we_i = we; cmd_adr_i = adr; cmd_d_i = d;
      cmd_size_i = size; cmd_prot_i = prot;
      step();
      cmd_valid_i = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({biu_stb_o, biu_we_o, biu_lock_o, rsp_valid_o, rsp_err_o, rsp_tmo_o} !== 6'b0) begin
         errors++; $display("FAIL reset_flags got %b want 000000",
            {biu_stb_o, biu_we_o, biu_lock_o, rsp_valid_o, rsp_err_o, rsp_tmo_o});
      end
      checks++;
      if ({biu_adri_o, biu_d_o, rsp_q_o, biu_size_o, biu_type_o, biu_prot_o} !== '0) begin
         errors++; $display("FAIL reset_fields adr=%h d=%h q=%h want 0", biu_adri_o, biu_d_o, rsp_q_o);
      end
      step(); step();
      rst = 1'b0;
      step();
      checks++;
      if (cmd_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready_o);
      end
   endtask

   task automatic test_write();
      send_cmd(1'b1, 64'h100, 64'hDEADBEEF, 3'b011, 3'b010);
      checks++;
      if ({biu_stb_o, biu_we_o, biu_adri_o, biu_d_o, biu_size_o, biu_prot_o, biu_type_o}
          !== {1'b1, 1'b1, 64'h100, 64'hDEADBEEF, 3'b011, 3'b010, 3'b000}) begin
         errors++; $display("FAIL write_req stb=%b we=%b adr=%h d=%h size=%b prot=%b type=%b want 1 1 100 deadbeef 011 010 000",
            biu_stb_o, biu_we_o, biu_adri_o, biu_d_o, biu_size_o, biu_prot_o, biu_type_o);
      end
      checks++;
      if (cmd_ready_o !== 1'b0) begin
         errors++; $display("FAIL write_busy cmd_ready got %b want 0", cmd_ready_o);
      end
      step();
      checks++;
      if (biu_stb_o !== 1'b1) begin
         errors++; $display("FAIL write_stb_hold got %b want 1", biu_stb_o);
      end
      biu_stb_ack_i = 1'b1;
      step();
      biu_stb_ack_i = 1'b0;
      checks++;
      if ({biu_stb_o, rsp_valid_o} !== 2'b00) begin
         errors++; $display("FAIL write_wait stb,valid got %b want 00", {biu_stb_o, rsp_valid_o});
      end
      biu_ack_i = 1'b1; biu_q_i = 64'h5555;
      step();
      biu_ack_i = 1'b0;
      checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_tmo_o, rsp_q_o} !== {3'b100, 64'h0}) begin
         errors++; $display("FAIL write_rsp valid/err/tmo=%b q=%h want 100 q=0",
            {rsp_valid_o, rsp_err_o, rsp_tmo_o}, rsp_q_o);
      end
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      checks++;
      if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
         errors++; $display("FAIL write_done valid,ready got %b want 01", {rsp_valid_o, cmd_ready_o});
      end
   endtask

   task automatic test_read();
      send_cmd(1'b0, 64'h100, 64'h0, 3'b011, 3'b000);
      checks++;
      if ({biu_stb_o, biu_we_o} !== 2'b10) begin
         errors++; $display("FAIL read_req stb,we got %b want 10", {biu_stb_o, biu_we_o});
      end
      biu_stb_ack_i = 1'b1;
      step();
      biu_stb_ack_i = 1'b0;
      biu_ack_i = 1'b1; biu_q_i = 64'hDEADBEEF;
      step();
      biu_ack_i = 1'b0; biu_q_i = '0;
      checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_tmo_o, rsp_q_o} !== {3'b100, 64'hDEADBEEF}) begin
         errors++; $display("FAIL read_rsp valid/err/tmo=%b q=%h want 100 q=deadbeef",
            {rsp_valid_o, rsp_err_o, rsp_tmo_o}, rsp_q_o);
      end
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_min_latency();
      send_cmd(1'b0, 64'h200, 64'h0, 3'b010, 3'b000);
      checks++;
      if ({biu_stb_o, rsp_valid_o} !== 2'b10) begin
         errors++; $display("FAIL minlat_first stb,valid got %b want 10", {biu_stb_o, rsp_valid_o});
      end
      biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1; biu_q_i = 64'h0123_4567_89AB_CDEF;
      step();
      biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0; biu_q_i = '0;
      checks++;
      if ({biu_stb_o, rsp_valid_o, rsp_err_o} !== 3'b010 || rsp_q_o !== 64'h0123_4567_89AB_CDEF) begin
         errors++; $display("FAIL minlat_rsp stb,valid,err=%b q=%h want 010 q=0123456789abcdef",
            {biu_stb_o, rsp_valid_o, rsp_err_o}, rsp_q_o);
      end
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_bus_error();
      send_cmd(1'b0, 64'h300, 64'h0, 3'b011, 3'b001);
      biu_stb_ack_i = 1'b1;
      step();
      biu_stb_ack_i = 1'b0;
      step();
      biu_ack_i = 1'b1; biu_err_i = 1'b1; biu_q_i = 64'hCAFE;
      step();
      biu_ack_i = 1'b0; biu_err_i = 1'b0; biu_q_i = '0;
      checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_tmo_o, rsp_q_o} !== {3'b110, 64'hCAFE}) begin
         errors++; $display("FAIL err_rsp valid/err/tmo=%b q=%h want 110 q=cafe",
            {rsp_valid_o, rsp_err_o, rsp_tmo_o}, rsp_q_o);
      end
      cmd_valid_i = 1'b1;
      step();
      step();
      checks++;
      if ({rsp_valid_o, rsp_err_o, rsp_q_o, biu_stb_o} !== {2'b11, 64'hCAFE, 1'b0}) begin
         errors++; $display("FAIL err_hold valid,err=%b q=%h stb=%b want 11 cafe 0",
            {rsp_valid_o, rsp_err_o}, rsp_q_o, biu_stb_o);
      end
      cmd_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
      send_cmd(1'b1, 64'h308, 64'h77, 3'b011, 3'b000);
      checks++;
      if ({biu_stb_o, biu_we_o, biu_adri_o} !== {2'b11, 64'h308}) begin
         errors++; $display("FAIL err_next stb,we=%b adr=%h want 11 308", {biu_stb_o, biu_we_o}, biu_adri_o);
      end
      biu_stb_ack_i = 1'b1; biu_ack_i = 1'b1;
      step();
      biu_stb_ack_i = 1'b0; biu_ack_i = 1'b0;
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_timeout();
      int n;
      send_cmd(1'b1, 64'h400, 64'h1, 3'b011, 3'b000);
      n = 0;
      while (rsp_valid_o !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      checks++;
      if (n !== 8) begin
         errors++; $display("FAIL tmo_cycles got %0d want 8", n);
      end
      checks++;
      if ({rsp_valid_o, rsp_tmo_o, rsp_err_o, biu_stb_o} !== 4'b1110) begin
         errors++; $display("FAIL tmo_rsp valid,tmo,err,stb got %b want 1110",
            {rsp_valid_o, rsp_tmo_o, rsp_err_o, biu_stb_o});
      end
      rsp_ready_i = 1'b1;
      step();
      rsp_ready_i = 1'b0;
   endtask

   task automatic test_ignore_idle_ack();
      biu_ack_i = 1'b1; biu_err_i = 1'b1; biu_stb_ack_i = 1'b1;
      step(); step();
      biu_ack_i = 1'b0; biu_err_i = 1'b0; biu_stb_ack_i = 1'b0;
      checks++;
      if ({rsp_valid_o, cmd_ready_o, biu_stb_o} !== 3'b010) begin
         errors++; $display("FAIL idle_ack valid,ready,stb got %b want 010",
            {rsp_valid_o, cmd_ready_o, biu_stb_o});
      end
   endtask

   task automatic test_reset_mid();
      int seen;
      send_cmd(1'b1, 64'h500, 64'hABCD, 3'b011, 3'b011);
      biu_stb_ack_i = 1'b1;
      step();
      biu_stb_ack_i = 1'b0;
      rsp_ready_i = 1'b0;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({biu_stb_o, biu_we_o, rsp_valid_o, rsp_err_o, rsp_tmo_o} !== 5'b0 ||
          {biu_adri_o, biu_d_o, biu_size_o, biu_prot_o, rsp_q_o} !== '0) begin
         errors++; $display("FAIL rstmid_async stb=%b we=%b valid=%b adr=%h d=%h want all 0",
            biu_stb_o, biu_we_o, rsp_valid_o, biu_adri_o, biu_d_o);
      end
      step();
      rst = 1'b0;
      biu_ack_i = 1'b1;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (rsp_valid_o !== 1'b0) seen++;
      end
      biu_ack_i = 1'b0;
      checks++;
      if (seen !== 0 || cmd_ready_o !== 1'b1) begin
         errors++; $display("FAIL rstmid_norsp valid_cycles=%0d ready=%b want 0 1", seen, cmd_ready_o);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_min_latency();
      test_bus_error();
      test_timeout();
      test_ignore_idle_ack();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
